// File: rtl/conv_output_accumulator_if.sv
// Partial-result input stream and quantised pixel output stream of the accumulator.
// The block owns the slave side; the upstream PE chain and next layer form the master side.
interface conv_output_accumulator_if #(
    parameter int I_BW = 19,
    parameter int Q_BW = 8
);
    logic                   i_valid;
    logic                   o_ready;
    logic signed [I_BW-1:0] i_y;
    logic                   o_valid;
    logic                   i_ready;
    logic signed [Q_BW-1:0] o_q;
    logic                   o_sat;

    modport slave  (input  i_valid, i_y, i_ready, output o_ready, o_valid, o_q, o_sat);
    modport master (output i_valid, i_y, i_ready, input  o_ready, o_valid, o_q, o_sat);
endinterface

// File: rtl/conv_output_accumulator.sv
// Sums C_IN channel partials per pixel, then ReLU / round-half-up shift / saturate; result visible the cycle after the last accept.
// 2-entry output buffer; o_ready drops only when the buffer is full and never depends on i_ready.
module conv_output_accumulator #(
    parameter int I_BW  = 19,
    parameter int C_IN  = 3,
    parameter int SHIFT = 4,
    parameter int Q_BW  = 8,
    parameter int RELU  = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    conv_output_accumulator_if.slave   io_bus
);
    localparam int ACC_BW = I_BW + $clog2(C_IN);
    localparam int CNT_BW = (C_IN > 1) ? $clog2(C_IN) : 1;
    localparam logic [CNT_BW-1:0]     LAST = CNT_BW'(C_IN - 1);
    localparam logic signed [ACC_BW:0] QMAX = {{(ACC_BW + 2 - Q_BW){1'b0}}, {(Q_BW - 1){1'b1}}};
    localparam logic signed [ACC_BW:0] QMIN = {{(ACC_BW + 2 - Q_BW){1'b1}}, {(Q_BW - 1){1'b0}}};

    logic [CNT_BW-1:0]        r_ch_cnt;
    logic signed [ACC_BW-1:0] r_acc;
    logic [Q_BW-1:0]          r_buf0;
    logic [Q_BW-1:0]          r_buf1;
    logic [1:0]               r_cnt;
    logic                     r_sat;

    logic                     w_accept;
    logic                     w_last;
    logic                     w_enq;
    logic                     w_deq;
    logic signed [ACC_BW:0]   w_y_ext;
    logic signed [ACC_BW:0]   w_base;
    logic signed [ACC_BW:0]   w_sum;
    logic signed [ACC_BW:0]   w_relu;
    logic signed [ACC_BW:0]   w_shf;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [Q_BW-1:0]          w_q;

    assign io_bus.o_ready = (r_cnt < 2'd2);
    assign io_bus.o_valid = (r_cnt != 2'd0);
    assign io_bus.o_q     = (r_cnt != 2'd0) ? r_buf0 : '0;
    assign io_bus.o_sat   = r_sat;

    assign w_accept = io_bus.i_valid & io_bus.o_ready;
    assign w_last   = (r_ch_cnt == LAST);
    assign w_enq    = w_accept & w_last;
    assign w_deq    = io_bus.o_valid & io_bus.i_ready;

    // The first channel of a pixel ignores whatever the accumulator still holds.
    assign w_y_ext = {{(ACC_BW + 1 - I_BW){io_bus.i_y[I_BW-1]}}, io_bus.i_y};
    assign w_base  = (r_ch_cnt == '0) ? '0 : {r_acc[ACC_BW-1], r_acc};
    assign w_sum   = w_base + w_y_ext;
    assign w_relu  = ((RELU != 0) && w_sum[ACC_BW]) ? '0 : w_sum;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_BW:0] HALF = (ACC_BW + 1)'(1) << (SHIFT - 1);
            assign w_shf = (w_relu + HALF) >>> SHIFT;
        end else begin : g_no_round
            assign w_shf = w_relu;
        end
    endgenerate

    assign w_sat_hi = (w_shf > QMAX);
    assign w_sat_lo = (w_shf < QMIN);
    assign w_q      = w_sat_hi ? QMAX[Q_BW-1:0] : (w_sat_lo ? QMIN[Q_BW-1:0] : w_shf[Q_BW-1:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch_cnt <= '0;
            r_acc    <= '0;
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_cnt    <= 2'd0;
            r_sat    <= 1'b0;
        end else if (i_clear) begin
            r_ch_cnt <= '0;
            r_acc    <= '0;
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_cnt    <= 2'd0;
            r_sat    <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_ch_cnt <= '0;
                end else begin
                    r_ch_cnt <= r_ch_cnt + 1'b1;
                    r_acc    <= w_sum[ACC_BW-1:0];
                end
            end
            if (w_enq && (w_sat_hi || w_sat_lo)) begin
                r_sat <= 1'b1;
            end
            // Enqueue while full cannot happen, so enq+deq always finds exactly one entry.
            case ({w_enq, w_deq})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_buf0 <= w_q;
                    end else begin
                        r_buf1 <= w_q;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    r_buf0 <= w_q;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_output_accumulator.sv
module tb_conv_output_accumulator;
    localparam int I_BW  = 19;
    localparam int C_IN  = 3;
    localparam int SHIFT = 4;
    localparam int Q_BW  = 8;
    localparam longint QMAX = (longint'(1) <<< (Q_BW - 1)) - 1;
    localparam longint QMIN = -(longint'(1) <<< (Q_BW - 1));

    logic clk = 1'b0;
    logic rst_n, clr, vld, rdy;
    logic signed [I_BW-1:0] y_d;
    bit   rnd_rdy;

    always #5 clk = ~clk;

    conv_output_accumulator_if #(.I_BW(I_BW), .Q_BW(Q_BW)) if_r ();
    conv_output_accumulator_if #(.I_BW(I_BW), .Q_BW(Q_BW)) if_n ();

    assign if_r.i_valid = vld;
    assign if_r.i_y     = y_d;
    assign if_r.i_ready = rdy;
    assign if_n.i_valid = vld;
    assign if_n.i_y     = y_d;
    assign if_n.i_ready = rdy;

    conv_output_accumulator #(.I_BW(I_BW), .C_IN(C_IN), .SHIFT(SHIFT), .Q_BW(Q_BW), .RELU(1)) u_dut_relu (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .io_bus(if_r));
    conv_output_accumulator #(.I_BW(I_BW), .C_IN(C_IN), .SHIFT(SHIFT), .Q_BW(Q_BW), .RELU(0)) u_dut_norelu (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .io_bus(if_n));

    // Reference model state: expected output buffers and the pixel being gathered.
    longint q_r[$];
    longint q_n[$];
    bit     sat_r, sat_n;
    longint ch_sum;
    int     ch_n;
    int     n_acc;
    longint last_r, last_n;
    int     n_chk = 0;
    int     n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint x, input longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic longint quant(input longint s_in, input bit relu, output bit sat);
        longint s;
        s   = s_in;
        sat = 1'b0;
        if (relu && s < 0) s = 0;
        if (SHIFT > 0) s = floor_div(s + (longint'(1) <<< (SHIFT - 1)), longint'(1) <<< SHIFT);
        if (s > QMAX) begin
            s = QMAX; sat = 1'b1;
        end else if (s < QMIN) begin
            s = QMIN; sat = 1'b1;
        end
        return s;
    endfunction

    task automatic model_flush();
        q_r.delete(); q_n.delete();
        sat_r = 1'b0; sat_n = 1'b0;
        ch_sum = 0; ch_n = 0;
    endtask

    // Monitor: compare the settled outputs, then predict what the coming edge does.
    always @(negedge clk) begin
        bit pre_acc, sr, sn;
        if (!rst_n) begin
            model_flush();
            chk("rst_valid", if_r.o_valid, 0);
            chk("rst_q", if_r.o_q, 0);
            chk("rst_sat_r", if_r.o_sat, 0);
            chk("rst_sat_n", if_n.o_sat, 0);
        end else begin
            chk("ready_r", if_r.o_ready, q_r.size() < 2);
            chk("ready_n", if_n.o_ready, q_n.size() < 2);
            chk("valid_r", if_r.o_valid, q_r.size() != 0);
            chk("valid_n", if_n.o_valid, q_n.size() != 0);
            chk("q_r", if_r.o_q, (q_r.size() != 0) ? q_r[0] : 0);
            chk("q_n", if_n.o_q, (q_n.size() != 0) ? q_n[0] : 0);
            chk("sat_r", if_r.o_sat, sat_r);
            chk("sat_n", if_n.o_sat, sat_n);
            if (clr) begin
                model_flush();
            end else begin
                pre_acc = vld && (q_r.size() < 2);
                if (rdy && q_r.size() != 0) begin
                    last_r = if_r.o_q;
                    void'(q_r.pop_front());
                end
                if (rdy && q_n.size() != 0) begin
                    last_n = if_n.o_q;
                    void'(q_n.pop_front());
                end
                if (pre_acc) begin
                    n_acc++;
                    ch_sum += y_d;
                    ch_n++;
                    if (ch_n == C_IN) begin
                        q_r.push_back(quant(ch_sum, 1'b1, sr));
                        q_n.push_back(quant(ch_sum, 1'b0, sn));
                        sat_r |= sr;
                        sat_n |= sn;
                        ch_sum = 0;
                        ch_n   = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) rdy = 1'($urandom);
    end

    task automatic send(input longint y);
        int  n;
        bit  ok;
        n   = 0;
        ok  = 1'b0;
        vld = 1'b1;
        y_d = I_BW'(y);
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = if_r.o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        vld = 1'b0;
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL send_timeout: got no accept after %0d cycles expected accept", n);
        end
    endtask

    task automatic pixel(input longint a, input longint b, input longint c);
        send(a); send(b); send(c);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((q_r.size() != 0 || q_n.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: got %0d entries pending expected 0", q_r.size());
        end
    endtask

    task automatic clear_pulse();
        clr = 1'b1; vld = 1'b1; y_d = 19'sd77;
        @(posedge clk);
        #1;
        clr = 1'b0; vld = 1'b0;
    endtask

    function automatic longint rand_y();
        case ($urandom_range(0, 3))
            0:       return longint'($urandom_range(0, (1 << I_BW) - 1)) - (longint'(1) <<< (I_BW - 1));
            1:       return longint'($urandom_range(0, 800)) - 400;
            2:       return (longint'(1) <<< (I_BW - 1)) - 1;
            default: return -(longint'(1) <<< (I_BW - 1));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; clr = 1'b0; vld = 1'b0; rdy = 1'b1; y_d = '0; rnd_rdy = 1'b0;
        ch_sum = 0; ch_n = 0; n_acc = 0; last_r = 0; last_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        pixel(100, 50, 10);   wait_empty(); chk("t2_q", last_r, 10);
        pixel(24, 0, 0);      wait_empty(); chk("t3_24", last_r, 2);
        pixel(23, 0, 0);      wait_empty(); chk("t3_23", last_r, 1);
        pixel(-500, 0, 0);    wait_empty(); chk("t3_relu", last_r, 0); chk("t3_relu_nosat", if_r.o_sat, 0);
        pixel(-40, 0, 0);     wait_empty(); chk("t3_m40_relu", last_r, 0); chk("t3_m40_norelu", last_n, -2);

        pixel(262143, 262143, 262143); wait_empty(); chk("t4_pos", last_r, 127); chk("t4_sat", if_r.o_sat, 1);
        pixel(100, 50, 10);   wait_empty(); chk("t4_after", last_r, 10); chk("t4_sticky", if_r.o_sat, 1);
        pixel(-262144, -262144, -262144); wait_empty();
        chk("t4_neg_relu", last_r, 0); chk("t4_neg", last_n, -128); chk("t4_sat_n", if_n.o_sat, 1);
        clear_pulse();
        chk("t4_clr_sat", if_r.o_sat, 0);

        rdy = 1'b0;
        n0  = n_acc;
        fork
            begin
                for (int i = 0; i < 9; i++) send(longint'($urandom_range(0, 2000)) - 1000);
            end
            begin
                repeat (14) @(posedge clk);
                #1;
                chk("bp_accepted", n_acc - n0, 6);
                chk("bp_ready", if_r.o_ready, 0);
                rdy = 1'b1;
            end
        join
        wait_empty();
        chk("bp_total", n_acc - n0, 9);

        rdy = 1'b0;
        pixel(5, 6, 7); send(1); send(2);
        clear_pulse();
        chk("t6_clr_valid", if_r.o_valid, 0);
        rdy = 1'b1;
        pixel(16, 16, 16);    wait_empty(); chk("t6_clr_q", last_r, 3);

        pixel(262143, 262143, 262143); wait_empty(); chk("t6_pre_sat", if_r.o_sat, 1);
        send(9); send(9);
        @(posedge clk); #3 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_sat_r", if_r.o_sat, 0); chk("t6_rst_sat_n", if_n.o_sat, 0);
        pixel(16, 16, 16);    wait_empty(); chk("t6_rst_q", last_r, 3); chk("t6_rst_q_n", last_n, 3);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(rand_y());
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
        rdy = 1'b1;
        wait_empty();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
